ram_loader: RTL

//  Initiator for the single-port 8K x 16 RAM. Registered read, write-on-load.

---
 rtl/ram_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
// Boot-time RAM loader: streams N program words into a single-port RAM, reads
// them back and compares additive checksums before releasing the system.
module ram_loader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 13,
  parameter int MAX_WORDS = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0] MAX_N = (ADDR_W + 1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERIFY,
    DRAIN,
    FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   last_idx;
  logic [DATA_W-1:0] wr_sum_q, wr_sum_d;
  logic [DATA_W-1:0] rd_sum_q, rd_sum_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              pass_q, pass_d;
  logic              error_q, error_d;

  assign last_idx = n_q - ONE;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    idx_d       = idx_q;
    wr_sum_d    = wr_sum_q;
    rd_sum_d    = rd_sum_q;
    checksum_d  = checksum_q;
    pass_d      = pass_q;
    error_d     = error_q;
    in_ready    = 1'b0;
    ram_load    = 1'b0;
    ram_data    = '0;
    ram_address = '0;

    unique case (state_q)
      IDLE: begin
        // A zero-length request is dropped without touching the result flags.
        if (start && word_count != '0) begin
          idx_d      = '0;
          wr_sum_d   = '0;
          rd_sum_d   = '0;
          pass_d     = 1'b0;
          checksum_d = '0;
          if (word_count > MAX_N) begin
            error_d = 1'b1;
            state_d = FINISH;
          end else begin
            error_d = 1'b0;
            n_d     = word_count;
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        in_ready    = 1'b1;
        ram_address = idx_q[ADDR_W-1:0];
        if (in_valid) begin
          ram_load = 1'b1;
          ram_data = in_data;
          wr_sum_d = wr_sum_q + in_data;
          idx_d    = idx_q + ONE;
          if (idx_q == last_idx) begin
            idx_d   = '0;
            state_d = VERIFY;
          end
        end
      end

      VERIFY: begin
        ram_address = idx_q[ADDR_W-1:0];
        idx_d       = idx_q + ONE;
        // Read data trails the address by one cycle, so the first cycle has nothing to add.
        if (idx_q != '0) rd_sum_d = rd_sum_q + ram_out;
        if (idx_q == last_idx) state_d = DRAIN;
      end

      DRAIN: begin
        ram_address = last_idx[ADDR_W-1:0];
        rd_sum_d    = rd_sum_q + ram_out;
        pass_d      = (rd_sum_d == wr_sum_q) && !error_q;
        checksum_d  = wr_sum_q;
        state_d     = FINISH;
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      wr_sum_q   <= '0;
      rd_sum_q   <= '0;
      checksum_q <= '0;
      pass_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      wr_sum_q   <= wr_sum_d;
      rd_sum_q   <= rd_sum_d;
      checksum_q <= checksum_d;
      pass_q     <= pass_d;
      error_q    <= error_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign pass     = pass_q;
  assign error    = error_q;
  assign checksum = checksum_q;

endmodule
